lock_cmd_arbiter: RTL and testbench
===================================

// Module: lock_cmd_arbiter
// PURPOSE
//  Upstream stage of the lock unit. Merges the per-accelerator lock/unlock command streams into
//  the single tagged command stream the lock unit consumes. Round-robin, one 64-bit word per command.
//  Output TID carries the index of the source accelerator, so the lock unit's ACK returns to the requester.
// PARAMETERS
//  ACC_BITS  4   width of the accelerator id on out_TID.
//  NUM_ACCS  16  number of command inputs. Legal range 2..2**ACC_BITS.
// PORTS
//  clk          in   1              clock
//  rstn         in   1              synchronous reset, active-low
//  in_TDATA     in   64*NUM_ACCS    command word of input i is at [64*i+63:64*i]
//  in_TVALID    in   NUM_ACCS       per-input valid
//  in_TREADY    out  NUM_ACCS       per-input ready; at most one bit high per cycle
//  out_TDATA    out  64             forwarded command word, unmodified
//  out_TVALID   out  1              output valid
//  out_TID      out  ACC_BITS       source input index, zero-extended
//  out_TREADY   in   1              lock unit ready
// BEHAVIOUR
//  Reset (rstn=0 at posedge):
//  - Output register is emptied: out_TVALID=0, out_TDATA=0, out_TID=0.
//  - rr_ptr=0.
//  - in_TREADY is forced to all zeros while rstn=0.
//  - A word held in the output register when reset arrives is discarded, not replayed.
//  Output register:
//  - Single stage: out_valid, out_data, out_tid.
//  - can_load = !out_valid || out_TREADY, i.e. empty, or being drained this cycle.
//  Grant (combinational):
//  - grant = first i with in_TVALID[i]=1, searching rr_ptr, rr_ptr+1, ... NUM_ACCS-1, 0, ... (wraps).
//  - any = |in_TVALID.
//  - in_TREADY[i] = rstn && can_load && any && (i==grant).
//  - in_TREADY must not depend on in_TVALID of the granted input alone; the search result suffices.
//  On posedge, when can_load && any:
//  - out_data <= word[grant]; out_tid <= grant; out_valid <= 1.
//  - rr_ptr <= (grant==NUM_ACCS-1) ? 0 : grant+1.
//  Else if out_TREADY && out_valid: out_valid <= 0. Otherwise hold; TDATA/TID stable while stalled.
//  Timing:
//  - Latency: a word accepted at edge N appears on out_* right after edge N. One registered cycle, no bubble.
//  - Throughput: 1 word/cycle under continuous out_TREADY.
//  - Simultaneous drain and load in one cycle is required. No drop, no duplicate.
//  Fairness:
//  - With all inputs valid, grants go 0,1,...,NUM_ACCS-1,0,...
//  - A continuously valid input waits at most NUM_ACCS-1 grants.
//  - Idle cycles do not move rr_ptr.
//  Boundary conditions:
//  - Single input valid: it is granted regardless of rr_ptr.
//  - Grant of the highest index: rr_ptr wraps to 0.
//  - A valid deasserted before its grant (protocol violation upstream) is simply not selected; no error.
//  - out_TREADY low with out_valid=1: every in_TREADY=0, no state change except in_* sampling.
//  Protocol: no payload decoding; TLAST is not used. Every command is exactly one beat.
// STRUCTURE
//  Shared package: none needed beyond the existing manager package; no new typedefs.
//  Sub-module rr_select #(.N(NUM_ACCS)):
//  - Inputs: req[N], ptr. Outputs: any, grant index.
//  - Implementation: doubled-vector masked priority encoder.
//  - Reused later by the ACK demux and by other command arbiters.
//  Top level: output register, rr_ptr register, in_TREADY decode. No FSM beyond out_valid.
// TESTING
//  1. Reset with inputs idle -> out_TVALID=0, in_TREADY=0.
//     Send in 3 word 0xA5 -> out_TDATA=0xA5 and out_TID=3 on the next cycle; in_TREADY[3] high 1 cycle.
//  2. All 16 inputs valid, out_TREADY=1 -> out_TID sequence 0,1,..,15,0,1.
//     out_TVALID high every cycle, no gaps.
//  3. Inputs 2 and 14 valid, rr_ptr=15 -> grant order 2,14,2,14 (wrap from 15 to 2).
//  4. out_TREADY=0 for 5 cycles with input 7 valid -> out_TDATA/out_TID stable, all in_TREADY=0.
//     Release -> exactly one copy, then the next word.
//  5. rstn low while out_TVALID=1 (TID=5) -> next cycle out_TVALID=0.
//     After release, input 0 is granted first (rr_ptr=0); the word from 5 is never emitted.
//  6. Random valid/ready over 10k cycles against a scoreboard:
//     every accepted word emitted once, in order, TID correct, no starvation beyond 15 grants.

Source files
------------

// File: rtl/lock_cmd_arbiter_pkg.sv
// Shared constants for the lock-unit command arbiter.
// Command word width and round-robin pointer helper.
package lock_cmd_arbiter_pkg;

  localparam int CMD_W = 64;

  function automatic int rr_next(
    input int g,
    input int n
  );
    return (g == n - 1) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/lock_cmd_arbiter_rr_select.sv
// Round-robin select: first set request at or after ptr, wrapping.
// Doubled request vector with bits below ptr masked, then priority encoded.
module rr_select #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic         o_any,
  output logic [W-1:0] o_grant
);

  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_mask;
  logic           w_found;

  always_comb begin
    w_dbl   = {i_req, i_req};
    w_mask  = '0;
    w_found = 1'b0;
    o_grant = '0;
    for (int j = 0; j < 2 * N; j++) begin
      w_mask[j] = w_dbl[j] && (j >= int'(i_ptr));
      if (w_mask[j] && !w_found) begin
        w_found = 1'b1;
        o_grant = W'(j % N);
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/lock_cmd_arbiter.sv
// Merges per-accelerator lock commands into one tagged stream.
// Round-robin grant into a single output register; TID = source index.
module lock_cmd_arbiter
  import lock_cmd_arbiter_pkg::*;
#(
  parameter int ACC_BITS = 4,
  parameter int NUM_ACCS = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [CMD_W*NUM_ACCS-1:0] in_TDATA,
  input  logic [NUM_ACCS-1:0]       in_TVALID,
  output logic [NUM_ACCS-1:0]       in_TREADY,
  output logic [CMD_W-1:0]          out_TDATA,
  output logic                      out_TVALID,
  output logic [ACC_BITS-1:0]       out_TID,
  input  logic                      out_TREADY
);

  logic                r_out_valid;
  logic [CMD_W-1:0]    r_out_data;
  logic [ACC_BITS-1:0] r_out_tid;
  logic [ACC_BITS-1:0] r_rr_ptr;

  logic                w_any;
  logic [ACC_BITS-1:0] w_grant;
  logic                w_can_load;
  logic                w_load;
  logic [CMD_W-1:0]    w_word;
  logic [ACC_BITS-1:0] w_ptr_nxt;

  rr_select #(
    .N(NUM_ACCS),
    .W(ACC_BITS)
  ) u_sel (
    .i_req  (in_TVALID),
    .i_ptr  (r_rr_ptr),
    .o_any  (w_any),
    .o_grant(w_grant)
  );

  assign w_can_load = !r_out_valid || out_TREADY;
  assign w_load     = w_can_load && w_any;
  assign w_word     = in_TDATA[CMD_W*int'(w_grant) +: CMD_W];
  assign w_ptr_nxt  = ACC_BITS'(rr_next(int'(w_grant), NUM_ACCS));

  // Ready is gated by rstn so nothing is acked while in reset.
  always_comb begin
    in_TREADY = '0;
    if (rstn && w_load) begin
      in_TREADY[w_grant] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_tid   <= '0;
      r_rr_ptr    <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_word;
      r_out_tid   <= w_grant;
      r_rr_ptr    <= w_ptr_nxt;
    end else if (out_TREADY && r_out_valid) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_TVALID = r_out_valid;
  assign out_TDATA  = r_out_data;
  assign out_TID    = r_out_tid;

endmodule

// File: tb/tb_lock_cmd_arbiter.sv
// Self-checking bench for lock_cmd_arbiter.
// Directed scenarios plus a randomized scoreboard run.
module tb_lock_cmd_arbiter;

  localparam int N  = 16;
  localparam int AB = 4;

  logic            clk;
  logic            rstn;
  logic [64*N-1:0] in_TDATA;
  logic [N-1:0]    in_TVALID;
  logic [N-1:0]    in_TREADY;
  logic [63:0]     out_TDATA;
  logic            out_TVALID;
  logic [AB-1:0]   out_TID;
  logic            out_TREADY;

  typedef struct packed {
    logic [AB-1:0] tid;
    logic [63:0]   data;
  } exp_t;

  exp_t exp_q[$];
  int   errors;
  int   checks;

  lock_cmd_arbiter #(
    .ACC_BITS(AB),
    .NUM_ACCS(N)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_TDATA  (in_TDATA),
    .in_TVALID (in_TVALID),
    .in_TREADY (in_TREADY),
    .out_TDATA (out_TDATA),
    .out_TVALID(out_TVALID),
    .out_TID   (out_TID),
    .out_TREADY(out_TREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic set_word(input int i, input logic [63:0] d);
    in_TDATA[64*i +: 64] = d;
  endtask

  task automatic push_exp(input int g, input logic [63:0] d);
    exp_t e;
    e.tid  = AB'(g);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reset;
    @(posedge clk); #1;
    rstn = 1'b0;
    in_TVALID = '0;
    out_TREADY = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    in_TVALID = '0;
    in_TDATA = '0;
    out_TREADY = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_TVALID[3] = 1'b1;
    @(negedge clk);
    checks++;
    if (out_TVALID !== 1'b0 || out_TID !== '0 || out_TDATA !== '0) begin
      errors++;
      $display("FAIL reset_out: got v=%b tid=%0d d=%h want 0",
               out_TVALID, out_TID, out_TDATA);
    end
    checks++;
    if (in_TREADY !== '0) begin
      errors++;
      $display("FAIL reset_ready: got %h want 0", in_TREADY);
    end
    @(posedge clk); #1;
    in_TVALID = '0;
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (out_TVALID !== 1'b0 || in_TREADY !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: got v=%b rdy=%h want 0",
               out_TVALID, in_TREADY);
    end
  endtask

  task automatic test_single;
    exp_t e;
    @(posedge clk); #1;
    set_word(3, 64'hA5);
    in_TVALID[3] = 1'b1;
    push_exp(3, 64'hA5);
    @(negedge clk);
    checks++;
    if (in_TREADY !== 16'h0008) begin
      errors++;
      $display("FAIL single_ready: got %h want 0008", in_TREADY);
    end
    @(posedge clk); #1;
    in_TVALID = '0;
    @(negedge clk);
    checks++;
    if (out_TVALID !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL single_valid: got %b want 1", out_TVALID);
    end else begin
      e = exp_q.pop_front();
      if (out_TDATA !== e.data || out_TID !== e.tid) begin
        errors++;
        $display("FAIL single_out: got tid=%0d d=%h want tid=%0d d=%h",
                 out_TID, out_TDATA, e.tid, e.data);
      end
    end
    checks++;
    if (in_TREADY !== '0) begin
      errors++;
      $display("FAIL single_ready_pulse: got %h want 0", in_TREADY);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_TVALID !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: got %b want 0", out_TVALID);
    end
  endtask

  task automatic test_all_rr;
    exp_t          e;
    logic [N-1:0]  ex;
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) set_word(i, 64'h1000 + 64'(i));
    in_TVALID = '1;
    for (int k = 0; k <= 18; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        checks++;
        if (out_TVALID !== 1'b1 || exp_q.size() == 0) begin
          errors++;
          $display("FAIL rr_valid k=%0d: got %b want 1", k, out_TVALID);
        end else begin
          e = exp_q.pop_front();
          if (out_TID !== e.tid || out_TDATA !== e.data) begin
            errors++;
            $display("FAIL rr_out k=%0d: got tid=%0d want tid=%0d",
                     k, out_TID, e.tid);
          end
        end
      end
      if (k < 18) begin
        ex = '0;
        ex[k % N] = 1'b1;
        checks++;
        if (in_TREADY !== ex) begin
          errors++;
          $display("FAIL rr_ready k=%0d: got %h want %h", k, in_TREADY, ex);
        end
        push_exp(k % N, 64'h1000 + 64'(k % N));
      end
      @(posedge clk); #1;
      if (k == 17) in_TVALID = '0;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rr_leftover: got %0d want 0", exp_q.size());
    end
  endtask

  task automatic test_wrap;
    exp_t         e;
    logic [N-1:0] ex;
    int           ord[4];
    ord = '{2, 14, 2, 14};
    do_reset();
    @(posedge clk); #1;
    set_word(14, 64'hE14);
    in_TVALID[14] = 1'b1;
    push_exp(14, 64'hE14);
    @(negedge clk);
    checks++;
    if (in_TREADY !== 16'h4000) begin
      errors++;
      $display("FAIL wrap_setup: got %h want 4000", in_TREADY);
    end
    @(posedge clk); #1;
    in_TVALID = '0;
    @(negedge clk);
    void'(exp_q.pop_front());
    @(posedge clk); #1;
    set_word(2, 64'h222);
    in_TVALID[2] = 1'b1;
    in_TVALID[14] = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        checks++;
        if (out_TVALID !== 1'b1 || exp_q.size() == 0) begin
          errors++;
          $display("FAIL wrap_valid k=%0d: got %b want 1", k, out_TVALID);
        end else begin
          e = exp_q.pop_front();
          if (out_TID !== e.tid || out_TDATA !== e.data) begin
            errors++;
            $display("FAIL wrap_out k=%0d: got tid=%0d want tid=%0d",
                     k, out_TID, e.tid);
          end
        end
      end
      if (k < 4) begin
        ex = '0;
        ex[ord[k]] = 1'b1;
        checks++;
        if (in_TREADY !== ex) begin
          errors++;
          $display("FAIL wrap_ready k=%0d: got %h want %h", k, in_TREADY, ex);
        end
        push_exp(ord[k], ord[k] == 2 ? 64'h222 : 64'hE14);
      end
      @(posedge clk); #1;
      if (k == 3) in_TVALID = '0;
    end
  endtask

  task automatic test_stall;
    exp_t e;
    @(posedge clk); #1;
    out_TREADY = 1'b0;
    set_word(7, 64'hD1D1);
    in_TVALID[7] = 1'b1;
    @(negedge clk);
    checks++;
    if (in_TREADY !== 16'h0080) begin
      errors++;
      $display("FAIL stall_load: got %h want 0080", in_TREADY);
    end
    push_exp(7, 64'hD1D1);
    @(posedge clk); #1;
    set_word(7, 64'hD2D2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (out_TVALID !== 1'b1 || out_TDATA !== 64'hD1D1 || out_TID !== 4'd7) begin
        errors++;
        $display("FAIL stall_hold k=%0d: got v=%b tid=%0d d=%h want 1/7/d1d1",
                 k, out_TVALID, out_TID, out_TDATA);
      end
      checks++;
      if (in_TREADY !== '0) begin
        errors++;
        $display("FAIL stall_ready k=%0d: got %h want 0", k, in_TREADY);
      end
      @(posedge clk); #1;
    end
    out_TREADY = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (out_TVALID !== 1'b1 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL stall_rel_valid k=%0d: got %b want 1", k, out_TVALID);
      end else begin
        e = exp_q.pop_front();
        if (out_TDATA !== e.data || out_TID !== e.tid) begin
          errors++;
          $display("FAIL stall_rel_out k=%0d: got d=%h want d=%h",
                   k, out_TDATA, e.data);
        end
      end
      if (k == 0) begin
        checks++;
        if (in_TREADY !== 16'h0080) begin
          errors++;
          $display("FAIL stall_reload: got %h want 0080", in_TREADY);
        end
        push_exp(7, 64'hD2D2);
      end
      @(posedge clk); #1;
      in_TVALID = '0;
    end
    @(negedge clk);
    checks++;
    if (out_TVALID !== 1'b0) begin
      errors++;
      $display("FAIL stall_dup: got %b want 0", out_TVALID);
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    @(posedge clk); #1;
    out_TREADY = 1'b0;
    set_word(5, 64'h5555);
    in_TVALID[5] = 1'b1;
    @(posedge clk); #1;
    in_TVALID = '0;
    @(negedge clk);
    checks++;
    if (out_TVALID !== 1'b1 || out_TID !== 4'd5) begin
      errors++;
      $display("FAIL rmid_setup: got v=%b tid=%0d want 1/5", out_TVALID, out_TID);
    end
    rstn = 1'b0;
    set_word(0, 64'hA0);
    set_word(9, 64'h99);
    in_TVALID[0] = 1'b1;
    in_TVALID[9] = 1'b1;
    @(posedge clk); #1;
    out_TREADY = 1'b1;
    @(negedge clk);
    checks++;
    if (out_TVALID !== 1'b0 || in_TREADY !== '0) begin
      errors++;
      $display("FAIL rmid_flush: got v=%b rdy=%h want 0/0", out_TVALID, in_TREADY);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (in_TREADY !== 16'h0001) begin
      errors++;
      $display("FAIL rmid_ptr: got %h want 0001", in_TREADY);
    end
    push_exp(0, 64'hA0);
    @(posedge clk); #1;
    in_TVALID = '0;
    @(negedge clk);
    checks++;
    if (out_TVALID !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL rmid_valid: got %b want 1", out_TVALID);
    end else begin
      e = exp_q.pop_front();
      if (out_TID !== e.tid || out_TDATA !== e.data) begin
        errors++;
        $display("FAIL rmid_out: got tid=%0d d=%h want tid=%0d d=%h",
                 out_TID, out_TDATA, e.tid, e.data);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_TVALID !== 1'b0) begin
      errors++;
      $display("FAIL rmid_replay: got %b want 0", out_TVALID);
    end
  endtask

  task automatic test_random;
    exp_t         e;
    logic [63:0]  word[N];
    int           wt[N];
    logic [N-1:0] acc_last;
    logic [N-1:0] ex;
    int           mptr;
    bit           mvalid;
    bit           can;
    int           g;
    int           maxw;
    int           idx;
    do_reset();
    mptr = 0;
    mvalid = 1'b0;
    acc_last = '0;
    for (int i = 0; i < N; i++) begin
      wt[i] = 0;
      word[i] = '0;
    end
    for (int c = 0; c < 10040; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (!in_TVALID[i] || acc_last[i]) begin
          in_TVALID[i] = (c < 10000) && ($urandom_range(0, 2) != 0);
          word[i] = {$urandom, $urandom};
          set_word(i, word[i]);
        end
      end
      out_TREADY = (c >= 10000) || ($urandom_range(0, 3) != 0);
      @(negedge clk);
      g = -1;
      for (int k = 0; k < N; k++) begin
        idx = (mptr + k) % N;
        if (g < 0 && in_TVALID[idx]) g = idx;
      end
      can = !mvalid || out_TREADY;
      checks++;
      if (out_TVALID !== mvalid) begin
        errors++;
        $display("FAIL rnd_valid c=%0d: got %b want %b", c, out_TVALID, mvalid);
      end
      if (out_TVALID && out_TREADY) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rnd_extra c=%0d: got tid=%0d want none", c, out_TID);
        end else begin
          e = exp_q.pop_front();
          if (out_TID !== e.tid || out_TDATA !== e.data) begin
            errors++;
            $display("FAIL rnd_out c=%0d: got tid=%0d d=%h want tid=%0d d=%h",
                     c, out_TID, out_TDATA, e.tid, e.data);
          end
        end
      end
      ex = '0;
      if (can && g >= 0) ex[g] = 1'b1;
      checks++;
      if (in_TREADY !== ex) begin
        errors++;
        $display("FAIL rnd_ready c=%0d: got %h want %h", c, in_TREADY, ex);
      end
      acc_last = ex;
      if (can && g >= 0) begin
        push_exp(g, word[g]);
        maxw = 0;
        for (int i = 0; i < N; i++) begin
          if (i == g) wt[i] = 0;
          else if (in_TVALID[i]) wt[i]++;
          if (wt[i] > maxw) maxw = wt[i];
        end
        checks++;
        if (maxw > N - 1) begin
          errors++;
          $display("FAIL rnd_starve c=%0d: got wait %0d want <= %0d", c, maxw, N - 1);
        end
        mptr = (g == N - 1) ? 0 : g + 1;
        mvalid = 1'b1;
      end else if (out_TREADY) begin
        mvalid = 1'b0;
      end
    end
    checks++;
    if (exp_q.size() != 0 || out_TVALID !== 1'b0) begin
      errors++;
      $display("FAIL rnd_drain: got q=%0d v=%b want 0/0", exp_q.size(), out_TVALID);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single();
    test_all_rr();
    test_wrap();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
